ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
- Elastic EX->MEM pipeline stage. Captures the ALU result and flags, store data, destination register and memory/write-back controls from the execute stage; presents them to the memory stage.
- Two-entry skid buffer (main + skid) with valid/ready handshakes on both sides, so memory-stage stalls never break a combinational ready path back into execute.
- Converts a trapped ALU overflow into an exception tag and suppresses all architectural side effects of that instruction.

Parameters:
- DW, 32, data width of ALU result, store data and PC
- RW, 5, register-index width

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of all buffered entries
- in_valid  in  1  execute stage presents an instruction
- in_ready  out  1  stage can accept; registered output
- in_pc  in  DW  instruction PC
- in_result  in  DW  ALU result
- in_zero  in  1  ALU zero flag
- in_overflow  in  1  ALU overflow flag
- in_ovf_trap_en  in  1  instruction traps on overflow (signed add/sub)
- in_store_data  in  DW  rt value for stores
- in_rd  in  RW  destination register
- in_reg_write, in_mem_read, in_mem_write, in_mem_to_reg  in  1 each  control bits
- out_valid  out  1  memory stage entry valid
- out_ready  in  1  memory stage accepts
- out_pc, out_result, out_store_data  out  DW  registered copies
- out_zero  out  1
- out_rd  out  RW
- out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg  out  1 each
- out_exc_ovf  out  1  instruction raised overflow exception

Behaviour:
- Reset (rst_n low, asynchronous): state EMPTY; out_valid=0, in_ready=1; all out_* data and control = 0; skid contents = 0.
- Transfers: accept when in_valid&&in_ready; drain when out_valid&&out_ready (both evaluated on the same edge).
- Latency: one cycle from accepted input to out_valid when the stage is empty.
- Capture transform, applied at accept:
  - exc = in_overflow & in_ovf_trap_en.
  - If exc: reg_write, mem_read, mem_write and mem_to_reg stored as 0, exc_ovf stored as 1.
  - Otherwise all fields are stored unmodified and exc_ovf=0.
  - in_overflow without trap_en is ignored.
- FSM states:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: main valid, skid empty, in_ready=1.
  - FULL: main and skid valid, in_ready=0.
- Transitions:
  - EMPTY + accept -> ONE; input goes to main.
  - ONE + accept + drain -> ONE; input goes to main.
  - ONE + accept, no drain -> FULL; input goes to skid.
  - ONE + drain, no accept -> EMPTY.
  - FULL + drain -> ONE; skid moves to main.
  - FULL never accepts.
- in_ready is a registered function of the next state (1 unless next state is FULL). It never depends combinationally on out_ready.
- Order preserved: main always holds the older entry.
- Outputs come directly from the main register, with no combinational path from in_* to out_*.
- Output data is held stable while out_valid && !out_ready.
- Flush (synchronous, priority over handshakes):
  - Next state EMPTY, out_valid=0, in_ready=1.
  - Any in_valid presented in the flush cycle is discarded.
  - Main/skid control bits are cleared to 0, so no stale reg_write or mem_write is seen.
- Reset asserted mid-operation discards everything immediately, independent of clk. Deassertion takes effect at the next edge.
- out_zero is registered passthrough only; this stage performs no branch resolution.
- Width rule: all data fields are copied bit-exact with no extension or truncation.

Test Plan:
- Single op, out_ready=1: in_result=0x0000_0007, rd=5, reg_write=1 at cycle 0 -> cycle 1 out_valid=1, out_result=0x7, out_rd=5, out_reg_write=1; cycle 2 out_valid=0.
- Back-pressure: stream results 1,2,3 with out_ready=0 -> after 2 accepts in_ready=0, out_result=1 held. Raise out_ready -> outputs 1,2,3 in order, no loss or duplicate, in_ready returns to 1 one cycle after the first drain.
- Overflow trap: in_result=0x8000_0000, in_overflow=1, trap_en=1, reg_write=1, mem_write=1 -> out_exc_ovf=1, out_reg_write=0, out_mem_write=0, out_result=0x8000_0000. Same with trap_en=0 -> exc 0, controls intact.
- Flush in FULL state while in_valid=1 with in_result=0xDEAD_BEEF -> next cycle out_valid=0, in_ready=1, all out control bits 0; 0xDEAD_BEEF never appears on out_result.
- Async reset: drop rst_n between edges while in ONE with out_mem_write=1 -> out_valid and out_mem_write go 0 before the next clk edge; after release, the first accept appears one cycle later.
- Random valid/ready throughput (10k ops) against a reference queue model: in-order delivery, zero drops, full throughput (1 op/cycle) when out_ready is held high.

Source files
------------

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: elastic EX->MEM pipeline register built as a two-entry skid
// buffer (main + skid). Trapped ALU overflow is turned into an exception tag
// and the instruction's architectural side effects are suppressed.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous kill of all buffered entries
//   in_valid/in_ready execute-side handshake (in_ready registered)
//   in_*              instruction fields and controls from execute
//   out_valid/out_ready memory-side handshake
//   out_*             registered copies taken from the main entry
//   out_exc_ovf       instruction raised an overflow exception
module ex_mem_stage #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_pc,
  input  logic [DW-1:0] in_result,
  input  logic          in_zero,
  input  logic          in_overflow,
  input  logic          in_ovf_trap_en,
  input  logic [DW-1:0] in_store_data,
  input  logic [RW-1:0] in_rd,
  input  logic          in_reg_write,
  input  logic          in_mem_read,
  input  logic          in_mem_write,
  input  logic          in_mem_to_reg,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_pc,
  output logic [DW-1:0] out_result,
  output logic [DW-1:0] out_store_data,
  output logic          out_zero,
  output logic [RW-1:0] out_rd,
  output logic          out_reg_write,
  output logic          out_mem_read,
  output logic          out_mem_write,
  output logic          out_mem_to_reg,
  output logic          out_exc_ovf
);

  typedef struct packed {
    logic [DW-1:0] pc;
    logic [DW-1:0] result;
    logic [DW-1:0] store_data;
    logic          zero;
    logic [RW-1:0] rd;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          mem_to_reg;
    logic          exc_ovf;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;
  entry_t main_q;
  entry_t skid_q;
  entry_t cap;
  logic   accept;
  logic   drain;
  logic   exc;

  // Drops every side-effecting control bit of an entry.
  function automatic entry_t clr_ctrl(input entry_t e);
    entry_t r;
    r            = e;
    r.reg_write  = 1'b0;
    r.mem_read   = 1'b0;
    r.mem_write  = 1'b0;
    r.mem_to_reg = 1'b0;
    r.exc_ovf    = 1'b0;
    return r;
  endfunction

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;
  assign exc    = in_overflow & in_ovf_trap_en;

  // Capture transform: a trapped overflow keeps its data but loses its effects.
  always_comb begin
    cap.pc         = in_pc;
    cap.result     = in_result;
    cap.store_data = in_store_data;
    cap.zero       = in_zero;
    cap.rd         = in_rd;
    cap.reg_write  = in_reg_write  & ~exc;
    cap.mem_read   = in_mem_read   & ~exc;
    cap.mem_write  = in_mem_write  & ~exc;
    cap.mem_to_reg = in_mem_to_reg & ~exc;
    cap.exc_ovf    = exc;
  end

  // Next-state decode; flush wins over any handshake.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (accept) state_d = ONE;
        ONE: begin
          if (accept && !drain)      state_d = FULL;
          else if (!accept && drain) state_d = EMPTY;
        end
        FULL:    if (drain) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // State, handshake flags and entry storage; main always holds the older entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      main_q    <= '0;
      skid_q    <= '0;
    end else begin
      state_q   <= state_d;
      out_valid <= (state_d != EMPTY);
      in_ready  <= (state_d != FULL);
      if (flush) begin
        main_q <= clr_ctrl(main_q);
        skid_q <= clr_ctrl(skid_q);
      end else begin
        case (state_q)
          EMPTY: if (accept) main_q <= cap;
          ONE: begin
            if (accept && drain) main_q <= cap;
            else if (accept)     skid_q <= cap;
          end
          FULL:    if (drain) main_q <= skid_q;
          default: ;
        endcase
      end
    end
  end

  assign out_pc         = main_q.pc;
  assign out_result     = main_q.result;
  assign out_store_data = main_q.store_data;
  assign out_zero       = main_q.zero;
  assign out_rd         = main_q.rd;
  assign out_reg_write  = main_q.reg_write;
  assign out_mem_read   = main_q.mem_read;
  assign out_mem_write  = main_q.mem_write;
  assign out_mem_to_reg = main_q.mem_to_reg;
  assign out_exc_ovf    = main_q.exc_ovf;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Testbench for ex_mem_stage: directed scenarios followed by randomized
// valid/ready traffic checked against a FIFO-of-two reference model.
module tb_ex_mem_stage;
  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_pc;
  logic [DW-1:0] in_result;
  logic          in_zero;
  logic          in_overflow;
  logic          in_ovf_trap_en;
  logic [DW-1:0] in_store_data;
  logic [RW-1:0] in_rd;
  logic          in_reg_write;
  logic          in_mem_read;
  logic          in_mem_write;
  logic          in_mem_to_reg;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_pc;
  logic [DW-1:0] out_result;
  logic [DW-1:0] out_store_data;
  logic          out_zero;
  logic [RW-1:0] out_rd;
  logic          out_reg_write;
  logic          out_mem_read;
  logic          out_mem_write;
  logic          out_mem_to_reg;
  logic          out_exc_ovf;

  always #5 clk = ~clk;

  ex_mem_stage #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_result(in_result), .in_zero(in_zero),
    .in_overflow(in_overflow), .in_ovf_trap_en(in_ovf_trap_en),
    .in_store_data(in_store_data), .in_rd(in_rd),
    .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_mem_to_reg(in_mem_to_reg),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_result(out_result), .out_store_data(out_store_data),
    .out_zero(out_zero), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_mem_to_reg(out_mem_to_reg),
    .out_exc_ovf(out_exc_ovf)
  );

  typedef struct packed {
    logic [DW-1:0] pc;
    logic [DW-1:0] result;
    logic [DW-1:0] store_data;
    logic          zero;
    logic [RW-1:0] rd;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          mem_to_reg;
    logic          exc_ovf;
  } rec_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  rec_t q[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // What the memory stage should see for the instruction now on the inputs.
  function automatic rec_t expect_rec();
    rec_t r;
    logic trap;
    trap         = in_overflow && in_ovf_trap_en;
    r.pc         = in_pc;
    r.result     = in_result;
    r.store_data = in_store_data;
    r.zero       = in_zero;
    r.rd         = in_rd;
    r.reg_write  = trap ? 1'b0 : in_reg_write;
    r.mem_read   = trap ? 1'b0 : in_mem_read;
    r.mem_write  = trap ? 1'b0 : in_mem_write;
    r.mem_to_reg = trap ? 1'b0 : in_mem_to_reg;
    r.exc_ovf    = trap;
    return r;
  endfunction

  function automatic rec_t observed_rec();
    return {out_pc, out_result, out_store_data, out_zero, out_rd,
            out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg, out_exc_ovf};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    in_valid = 1'b0; in_pc = '0; in_result = '0; in_zero = 1'b0;
    in_overflow = 1'b0; in_ovf_trap_en = 1'b0; in_store_data = '0; in_rd = '0;
    in_reg_write = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0; in_mem_to_reg = 1'b0;
  endtask

  task automatic drive_op(input logic [DW-1:0] res, input logic [RW-1:0] rd,
                          input logic rw, input logic mw, input logic ovf, input logic trap);
    clear_in();
    in_valid = 1'b1; in_result = res; in_pc = res + 32'h100; in_rd = rd;
    in_reg_write = rw; in_mem_write = mw; in_overflow = ovf; in_ovf_trap_en = trap;
  endtask

  initial begin
    int cyc;
    int acc;
    int del;
    int thr;
    logic exp_rdy;
    logic do_acc;
    logic do_drn;
    rec_t head;

    // Reset state
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0; clear_in();
    #12;
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_fields", 128'(observed_rec()), 128'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Single op with out_ready high
    out_ready = 1'b1;
    drive_op(32'h7, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("single_valid", 128'(out_valid), 128'd1);
    chk("single_result", 128'(out_result), 128'h7);
    chk("single_rd", 128'(out_rd), 128'd5);
    chk("single_rw", 128'(out_reg_write), 128'd1);
    clear_in();
    tick();
    chk("single_gone", 128'(out_valid), 128'd0);

    // Back-pressure: 1,2,3 with out_ready low
    out_ready = 1'b0;
    drive_op(32'd1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("bp_rdy_one", 128'(in_ready), 128'd1);
    drive_op(32'd2, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("bp_rdy_full", 128'(in_ready), 128'd0);
    chk("bp_head1", 128'(out_result), 128'd1);
    drive_op(32'd3, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("bp_hold1", 128'(out_result), 128'd1);
    chk("bp_hold_rdy", 128'(in_ready), 128'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_head2", 128'(out_result), 128'd2);
    chk("bp_rdy_back", 128'(in_ready), 128'd1);
    tick();
    chk("bp_head3", 128'(out_result), 128'd3);
    chk("bp_valid3", 128'(out_valid), 128'd1);
    clear_in();
    tick();
    chk("bp_empty", 128'(out_valid), 128'd0);

    // Overflow with and without trap enable
    drive_op(32'h8000_0000, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    chk("ovf_exc", 128'(out_exc_ovf), 128'd1);
    chk("ovf_rw", 128'(out_reg_write), 128'd0);
    chk("ovf_mw", 128'(out_mem_write), 128'd0);
    chk("ovf_result", 128'(out_result), 128'h8000_0000);
    drive_op(32'h8000_0000, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    chk("novf_exc", 128'(out_exc_ovf), 128'd0);
    chk("novf_rw", 128'(out_reg_write), 128'd1);
    chk("novf_mw", 128'(out_mem_write), 128'd1);
    clear_in();
    tick();

    // Flush while FULL with a new op presented
    out_ready = 1'b0;
    drive_op(32'hA, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive_op(32'hB, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("fl_full", 128'(in_ready), 128'd0);
    drive_op(32'hDEAD_BEEF, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_valid", 128'(out_valid), 128'd0);
    chk("fl_rdy", 128'(in_ready), 128'd1);
    chk("fl_ctrl", 128'({out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg, out_exc_ovf}), 128'd0);
    chk("fl_nobeef", 128'(out_result == 32'hDEAD_BEEF), 128'd0);
    clear_in();
    out_ready = 1'b1;
    tick();
    chk("fl_still_empty", 128'(out_valid), 128'd0);
    chk("fl_nobeef2", 128'(out_result == 32'hDEAD_BEEF), 128'd0);

    // Asynchronous reset mid-operation
    out_ready = 1'b0;
    drive_op(32'h44, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    clear_in();
    chk("ar_pre_mw", 128'(out_mem_write), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 128'(out_valid), 128'd0);
    chk("ar_mw", 128'(out_mem_write), 128'd0);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    drive_op(32'h55, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("ar_first_valid", 128'(out_valid), 128'd1);
    chk("ar_first_result", 128'(out_result), 128'h55);
    clear_in();
    tick();
    chk("ar_drained", 128'(out_valid), 128'd0);

    // Randomized traffic against the reference queue
    q.delete();
    cyc = 0; acc = 0; del = 0;
    while (acc < 10000 && cyc < 60000) begin
      in_valid       = ($urandom_range(0, 3) != 0);
      out_ready      = ($urandom_range(0, 3) != 0);
      in_pc          = $urandom;
      in_result      = $urandom;
      in_store_data  = $urandom;
      in_zero        = 1'($urandom);
      in_rd          = RW'($urandom);
      in_overflow    = 1'($urandom);
      in_ovf_trap_en = 1'($urandom);
      in_reg_write   = 1'($urandom);
      in_mem_read    = 1'($urandom);
      in_mem_write   = 1'($urandom);
      in_mem_to_reg  = 1'($urandom);
      exp_rdy = (q.size() < 2);
      do_acc  = in_valid && exp_rdy;
      do_drn  = (q.size() > 0) && out_ready;
      tick();
      if (do_drn) begin
        void'(q.pop_front());
        del++;
      end
      if (do_acc) begin
        q.push_back(expect_rec());
        acc++;
      end
      chk("rnd_valid", 128'(out_valid), 128'(q.size() > 0));
      chk("rnd_ready", 128'(in_ready), 128'(q.size() < 2));
      if (q.size() > 0) begin
        head = q[0];
        chk("rnd_head", 128'(observed_rec()), 128'(head));
      end
      cyc++;
    end
    chk("rnd_budget", 128'(acc), 128'd10000);

    // Drain the remainder
    clear_in();
    out_ready = 1'b1;
    cyc = 0;
    while (q.size() > 0 && cyc < 10) begin
      head = q[0];
      chk("drain_head", 128'(observed_rec()), 128'(head));
      tick();
      void'(q.pop_front());
      del++;
      cyc++;
    end
    chk("drain_done", 128'(out_valid), 128'd0);
    chk("no_loss", 128'(del), 128'(acc));

    // Full throughput with both sides always ready
    thr = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      drive_op(DW'(i * 3 + 1), RW'(i), 1'b1, 1'b0, 1'b0, 1'b0);
      if (in_ready) thr++;
      tick();
      chk("thr_result", 128'(out_result), 128'(i * 3 + 1));
      chk("thr_valid", 128'(out_valid), 128'd1);
    end
    chk("thr_count", 128'(thr), 128'd200);
    clear_in();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
